// File: rtl/reorder_add_sequencer_if.sv
// Stream-in / datapath / stream-out bundle for reorder_add_sequencer.
// master = the sequencer, slave = source, datapath and consumer side.
interface reorder_add_sequencer_if #(
  parameter int DATA_W  = 8,
  parameter int IDX_W   = 8,
  parameter int N_LANES = 9
) ();
  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          in_data;
  logic [IDX_W-1:0]           in_index;
  logic                       in_last;
  logic [N_LANES*DATA_W-1:0]  dp_data;
  logic [N_LANES*IDX_W-1:0]   dp_index;
  logic [N_LANES*DATA_W-1:0]  dp_res;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_data;
  logic                       out_last;
  logic                       busy;
  logic                       frame_done;
  logic                       err_idx;

  modport master (
    input  in_valid, in_data, in_index, in_last, dp_res, out_ready,
    output in_ready, dp_data, dp_index, out_valid, out_data, out_last,
           busy, frame_done, err_idx
  );

  modport slave (
    output in_valid, in_data, in_index, in_last, dp_res, out_ready,
    input  in_ready, dp_data, dp_index, out_valid, out_data, out_last,
           busy, frame_done, err_idx
  );
endinterface

// File: rtl/reorder_add_sequencer.sv
// Frame sequencer for the reorder_and_add datapath: serial load, parallel drive, serial drain.
// Optional REORDER_SEQ_IDX_CHECK_EN: out-of-range indices load as 0/0 and set sticky err_idx.
//   state   | meaning
//   S_LOAD  | accept pairs into lanes 0.. until lane N_LANES-1 or in_last
//   S_WAIT  | operands held on dp buses, wait DP_LATENCY cycles, capture dp_res
//   S_DRAIN | stream res_buf out lane by lane, then clear and return to S_LOAD
module reorder_add_sequencer #(
  parameter int DATA_W     = 8,
  parameter int IDX_W      = 8,
  parameter int N_LANES    = 9,
  parameter int DP_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  reorder_add_sequencer_if.master bus
);
  localparam int CNT_W  = $clog2(N_LANES + 1);
  localparam int WAIT_W = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;

  typedef enum logic [1:0] {S_LOAD, S_WAIT, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]   data_buf_q [N_LANES];
  logic [DATA_W-1:0]   data_buf_d [N_LANES];
  logic [IDX_W-1:0]    idx_buf_q  [N_LANES];
  logic [IDX_W-1:0]    idx_buf_d  [N_LANES];
  logic [DATA_W-1:0]   res_buf_q  [N_LANES];
  logic [DATA_W-1:0]   res_buf_d  [N_LANES];
  logic                frame_done_q, frame_done_d;

  logic                load_fire;
  logic [DATA_W-1:0]   ld_data;
  logic [IDX_W-1:0]    ld_idx;

  assign load_fire = (state_q == S_LOAD) && bus.in_valid;

`ifdef REORDER_SEQ_IDX_CHECK_EN
  logic idx_bad;
  logic err_q;

  assign idx_bad     = (bus.in_index >= IDX_W'(N_LANES));
  assign ld_data     = idx_bad ? '0 : bus.in_data;
  assign ld_idx      = idx_bad ? '0 : bus.in_index;
  assign bus.err_idx = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       err_q <= 1'b0;
    else if (load_fire && idx_bad) err_q <= 1'b1;
  end
`else
  assign ld_data     = bus.in_data;
  assign ld_idx      = bus.in_index;
  assign bus.err_idx = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LOAD;
      ld_cnt_q     <= '0;
      out_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      data_buf_q   <= '{default: '0};
      idx_buf_q    <= '{default: '0};
      res_buf_q    <= '{default: '0};
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      out_cnt_q    <= out_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      data_buf_q   <= data_buf_d;
      idx_buf_q    <= idx_buf_d;
      res_buf_q    <= res_buf_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    out_cnt_d    = out_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    data_buf_d   = data_buf_q;
    idx_buf_d    = idx_buf_q;
    res_buf_d    = res_buf_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (load_fire) begin
          for (int k = 0; k < N_LANES; k++) begin
            if (ld_cnt_q == CNT_W'(k)) begin
              data_buf_d[k] = ld_data;
              idx_buf_d[k]  = ld_idx;
            end
          end
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (bus.in_last || (ld_cnt_q == CNT_W'(N_LANES - 1))) begin
            state_d    = S_WAIT;
            wait_cnt_d = WAIT_W'(DP_LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          for (int k = 0; k < N_LANES; k++)
            res_buf_d[k] = bus.dp_res[k*DATA_W +: DATA_W];
          state_d = S_DRAIN;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (bus.out_ready) begin
          if (out_cnt_q == CNT_W'(N_LANES - 1)) begin
            // unloaded lanes of the next frame must read 0, so operands clear here
            state_d      = S_LOAD;
            out_cnt_d    = '0;
            ld_cnt_d     = '0;
            data_buf_d   = '{default: '0};
            idx_buf_d    = '{default: '0};
            frame_done_d = 1'b1;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  logic [N_LANES*DATA_W-1:0] dp_data_c;
  logic [N_LANES*IDX_W-1:0]  dp_index_c;
  logic [DATA_W-1:0]         out_data_c;

  always_comb begin
    dp_data_c  = '0;
    dp_index_c = '0;
    out_data_c = '0;
    for (int k = 0; k < N_LANES; k++) begin
      dp_data_c[k*DATA_W +: DATA_W] = data_buf_q[k];
      dp_index_c[k*IDX_W +: IDX_W]  = idx_buf_q[k];
      if ((state_q == S_DRAIN) && (out_cnt_q == CNT_W'(k)))
        out_data_c = res_buf_q[k];
    end
  end

  assign bus.in_ready   = (state_q == S_LOAD);
  assign bus.dp_data    = dp_data_c;
  assign bus.dp_index   = dp_index_c;
  assign bus.out_valid  = (state_q == S_DRAIN);
  assign bus.out_data   = out_data_c;
  assign bus.out_last   = (state_q == S_DRAIN) && (out_cnt_q == CNT_W'(N_LANES - 1));
  assign bus.busy       = !((state_q == S_LOAD) && (ld_cnt_q == '0));
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_reorder_add_sequencer.sv
// Bench for reorder_add_sequencer: stub datapath (res = data + index), frame-level model
// checked every cycle, plus literal per-frame result checks.
module tb_reorder_add_sequencer;
  localparam int N = 9;
  localparam int DW = 8;
  localparam int IW = 8;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reorder_add_sequencer_if #(.DATA_W(DW), .IDX_W(IW), .N_LANES(N)) bus ();

  reorder_add_sequencer #(.DATA_W(DW), .IDX_W(IW), .N_LANES(N), .DP_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always_comb begin
    bus.dp_res = '0;
    for (int k = 0; k < N; k++)
      bus.dp_res[k*DW +: DW] = bus.dp_data[k*DW +: DW] + bus.dp_index[k*IW +: IW];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_data [N];
  logic [7:0] m_idx  [N];
  logic [7:0] m_res  [N];
  int         m_cnt, m_phase, m_wait, m_out;  // phase 0 collecting, 1 waiting, 2 draining
  bit         m_fd, m_err;
  logic [7:0] got [$];
  int         cyc = 0, first_ld_cyc = 0, fd_cyc = 0;
  bit         fd_seen = 0;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin m_data[k] = 0; m_idx[k] = 0; m_res[k] = 0; end
    m_cnt = 0; m_phase = 0; m_wait = 0; m_out = 0; m_fd = 0; m_err = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    logic [71:0] ed, ei;
    logic [7:0]  d, i;
    cyc++;
    if (rst) model_reset();
    ed = '0; ei = '0;
    for (int k = 0; k < N; k++) begin ed[k*8 +: 8] = m_data[k]; ei[k*8 +: 8] = m_idx[k]; end
    chk("in_ready",   bus.in_ready,   m_phase == 0);
    chk("out_valid",  bus.out_valid,  m_phase == 2);
    chk("out_data",   bus.out_data,   (m_phase == 2) ? m_res[m_out] : 8'h00);
    chk("out_last",   bus.out_last,   (m_phase == 2) && (m_out == N - 1));
    chk("busy",       bus.busy,       !((m_phase == 0) && (m_cnt == 0)));
    chk("frame_done", bus.frame_done, m_fd);
    chk("err_idx",    bus.err_idx,    m_err);
    chk("dp_data",    bus.dp_data,    ed);
    chk("dp_index",   bus.dp_index,   ei);
    if (bus.frame_done) begin fd_cyc = cyc; fd_seen = 1; end
    if (!rst) begin
      m_fd = 0;
      case (m_phase)
        0: if (bus.in_valid) begin
          d = bus.in_data; i = bus.in_index;
`ifdef REORDER_SEQ_IDX_CHECK_EN
          if (i >= N) begin d = 0; i = 0; m_err = 1; end
`endif
          m_data[m_cnt] = d; m_idx[m_cnt] = i; m_cnt++;
          if (m_cnt == 1) first_ld_cyc = cyc;
          if (bus.in_last || m_cnt == N) begin m_phase = 1; m_wait = LAT; end
        end
        1: begin
          m_wait--;
          if (m_wait == 0) begin
            for (int k = 0; k < N; k++) m_res[k] = m_data[k] + m_idx[k];
            m_phase = 2; m_out = 0;
          end
        end
        default: if (bus.out_ready) begin
          got.push_back(bus.out_data);
          m_out++;
          if (m_out == N) begin
            m_fd = 1; m_phase = 0; m_cnt = 0;
            for (int k = 0; k < N; k++) begin m_data[k] = 0; m_idx[k] = 0; end
          end
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] td [N];
  logic [7:0] ti [N];

  function automatic logic [71:0] got_packed();
    logic [71:0] p = '0;
    for (int k = 0; k < N; k++) if (k < got.size()) p[k*8 +: 8] = got[k];
    return p;
  endfunction

  task automatic run_frame(input int n, input bit use_last, input bit gaps, input bit junk,
                           input int stall_lane, input int abort_lane);
    int stall_cnt = 0;
    bit done = 0;
    got.delete();
    fd_seen = 0;
    for (int k = 0; k < n; k++) begin
      if (gaps && (k % 3 == 1)) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_data = 8'hEE; bus.in_index = 8'hEE; bus.in_last = 1'b1;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_data = td[k]; bus.in_index = ti[k];
      bus.in_last  = use_last && (k == n - 1);
    end
    for (int t = 0; t < 80; t++) begin
      @(posedge clk); #1;
      bus.in_valid = junk && (t < 8);
      bus.in_data  = 8'hA5; bus.in_index = 8'h03; bus.in_last = 1'b1;
      if (abort_lane >= 0 && got.size() == abort_lane && bus.out_valid) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        done = 1;
        break;
      end
      if (got.size() == stall_lane && stall_cnt < 3 && bus.out_valid) begin
        bus.out_ready = 1'b0; stall_cnt++;
      end else begin
        bus.out_ready = 1'b1;
      end
      if (fd_seen) begin done = 1; break; end
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    chk("frame_timeout", done, 1'b1);
  endtask

  task automatic load_frame1();
    td = '{8'd0, 8'd2, 8'd4, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    ti = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd1, 8'd3, 8'd0, 8'd0, 8'd0};
  endtask

  localparam logic [71:0] EXP1 = {8'd0, 8'd0, 8'd0, 8'd3, 8'd1, 8'd9, 8'd6, 8'd3, 8'd0};

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_index = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: full frame, no stalls
    load_frame1();
    run_frame(9, 0, 0, 0, -1, -1);
    chk("t1_results", got_packed(), EXP1);
    chk("t1_count", got.size(), 9);
    chk("t1_fd_cycle", fd_cyc - first_ld_cyc, 19);  // frame_done lands in the 20th cycle

    // 2: early in_last on pair 3
    td = '{8'd5, 8'd6, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    ti = '{8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_frame(3, 1, 0, 0, -1, -1);
    chk("t2_results", got_packed(), {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd8, 8'd7, 8'd6});
    chk("t2_count", got.size(), 9);

    // 3: backpressure on lane 4, in_last on lane 8 is ordinary
    load_frame1();
    run_frame(9, 1, 0, 0, 4, -1);
    chk("t3_results", got_packed(), EXP1);
    chk("t3_count", got.size(), 9);

    // 4: valid gaps in LOAD, junk valid during WAIT/DRAIN
    td = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    ti = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    run_frame(9, 0, 1, 1, -1, -1);
    chk("t4_results", got_packed(), {9{8'd9}});
    chk("t4_count", got.size(), 9);

    // 5: reset during drain at lane 5, then a clean frame
    load_frame1();
    run_frame(9, 0, 0, 0, -1, 5);
    chk("t5_abort_count", got.size(), 5);
    @(posedge clk); #1;
    run_frame(9, 0, 0, 0, -1, -1);
    chk("t5_results", got_packed(), EXP1);

    // 6: out-of-range index on lane 2
    td = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    ti = '{8'd0, 8'd1, 8'd12, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_frame(3, 1, 0, 0, -1, -1);
    @(negedge clk);
`ifdef REORDER_SEQ_IDX_CHECK_EN
    chk("t6_results", got_packed(), {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd1});
    chk("t6_err_sticky", bus.err_idx, 1'b1);
`else
    chk("t6_results", got_packed(), {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd15, 8'd3, 8'd1});
    chk("t6_err_tied", bus.err_idx, 1'b0);
`endif
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_err_after_rst", bus.err_idx, 1'b0);
    chk("t6_ready_after_rst", bus.in_ready, 1'b1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
